// File: rtl/xmemctrl.sv
// xmemctrl: memory / on-chip bus controller between the CPU/DMA access
// pipeline, a narrow asynchronous external SRAM and the peripheral bus.
//
// An accepted access is latched and then run as one of:
//   - RAM read:  NBx beats of 1+RD_WS cycles each, with ram_oe_n low.
//   - RAM write: NBx beats of setup / pulse / hold, with xa and xd_o held stable.
//   - I/O:       one full-W transfer with a ready handshake and a timeout.
// NBx is W/XW for a word access and 1 for a byte access.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_ce                accept the *_nxt access (honoured only while rdy=1)
//   word_nxt, read_nxt,
//   dma_nxt, addr_nxt,
//   wdata_nxt             next access descriptor
//   rdy                   controller idle; rdata valid after a read
//   rdata                 read data
//   dma_ack               one-cycle pulse after a DMA access completes
//   xa, ram_oe_n,
//   ram_we_n, xd_o,
//   xd_oe, xd_i           external SRAM interface (ram_we_n comes from a flop)
//   sel, io_addr, io_rd,
//   io_wr, io_wdata,
//   io_rdata, io_rdy      peripheral bus
//   io_err                one-cycle pulse after an I/O timeout
module xmemctrl #(
  parameter int unsigned W        = 16,
  parameter int unsigned XW       = 8,
  parameter int unsigned AW       = 16,
  parameter int unsigned SELB     = 3,
  parameter int unsigned RD_WS    = 0,
  parameter int unsigned WR_SETUP = 1,
  parameter int unsigned WR_PULSE = 1,
  parameter int unsigned WR_HOLD  = 1,
  parameter int unsigned IO_TO    = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_ce,
  input  logic                 word_nxt,
  input  logic                 read_nxt,
  input  logic                 dma_nxt,
  input  logic [AW-1:0]        addr_nxt,
  input  logic [W-1:0]         wdata_nxt,
  output logic                 rdy,
  output logic [W-1:0]         rdata,
  output logic                 dma_ack,
  output logic [AW-1:0]        xa,
  output logic                 ram_oe_n,
  output logic                 ram_we_n,
  output logic [XW-1:0]        xd_o,
  output logic                 xd_oe,
  input  logic [XW-1:0]        xd_i,
  output logic [2**SELB-1:0]   sel,
  output logic [4:0]           io_addr,
  output logic                 io_rd,
  output logic                 io_wr,
  output logic [W-1:0]         io_wdata,
  input  logic [W-1:0]         io_rdata,
  input  logic                 io_rdy,
  output logic                 io_err
);

  localparam int unsigned NB      = W / XW;
  localparam int unsigned LB      = $clog2(NB);
  localparam int unsigned BW      = (LB > 0) ? LB : 1;
  localparam int unsigned M1      = (RD_WS + 1 > WR_SETUP) ? RD_WS + 1 : WR_SETUP;
  localparam int unsigned M2      = (M1 > WR_PULSE) ? M1 : WR_PULSE;
  localparam int unsigned WMAX    = (M2 > WR_HOLD) ? M2 : WR_HOLD;
  localparam int unsigned WCW     = (WMAX > 1) ? $clog2(WMAX) : 1;
  localparam int unsigned TCW     = (IO_TO > 1) ? $clog2(IO_TO) : 1;
  localparam int unsigned SU_LAST = (WR_SETUP > 0) ? WR_SETUP - 1 : 0;
  localparam int unsigned PL_LAST = WR_PULSE - 1;
  localparam int unsigned HD_LAST = (WR_HOLD > 0) ? WR_HOLD - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WSU,
    S_WPL,
    S_WHD,
    S_IO
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic            word_q, word_d;
  logic            read_q, read_d;
  logic            dma_q, dma_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [TCW-1:0]  tcnt_q, tcnt_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic            dma_ack_q, dma_ack_d;
  logic            io_err_q, io_err_d;
  logic            we_n_q, we_n_d;

  logic            last_beat;
  logic            wr_beat_done;

  assign last_beat = !word_q || (beat_q == BW'(NB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      word_q    <= 1'b0;
      read_q    <= 1'b0;
      dma_q     <= 1'b0;
      beat_q    <= '0;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      rdata_q   <= '0;
      dma_ack_q <= 1'b0;
      io_err_q  <= 1'b0;
      we_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      word_q    <= word_d;
      read_q    <= read_d;
      dma_q     <= dma_d;
      beat_q    <= beat_d;
      wcnt_q    <= wcnt_d;
      tcnt_q    <= tcnt_d;
      rdata_q   <= rdata_d;
      dma_ack_q <= dma_ack_d;
      io_err_q  <= io_err_d;
      we_n_q    <= we_n_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    read_d       = read_q;
    dma_d        = dma_q;
    beat_d       = beat_q;
    wcnt_d       = wcnt_q;
    tcnt_d       = tcnt_q;
    rdata_d      = rdata_q;
    dma_ack_d    = 1'b0;
    io_err_d     = 1'b0;
    wr_beat_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_ce) begin
          addr_d  = addr_nxt;
          wdata_d = wdata_nxt;
          word_d  = word_nxt;
          read_d  = read_nxt;
          dma_d   = dma_nxt;
          beat_d  = '0;
          wcnt_d  = '0;
          tcnt_d  = '0;
          if (&addr_nxt[AW-1:8])  state_d = S_IO;
          else if (read_nxt)      state_d = S_RD;
          else if (WR_SETUP > 0)  state_d = S_WSU;
          else                    state_d = S_WPL;
        end
      end

      S_RD: begin
        if (wcnt_q == WCW'(RD_WS)) begin
          if (word_q) begin
            rdata_d[beat_q*XW +: XW] = xd_i;
          end else begin
            rdata_d          = '0;
            rdata_d[XW-1:0]  = xd_i;
          end
          wcnt_d = '0;
          if (last_beat) begin
            state_d   = S_IDLE;
            dma_ack_d = dma_q;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      S_WSU: begin
        if (wcnt_q == WCW'(SU_LAST)) begin
          wcnt_d  = '0;
          state_d = S_WPL;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      S_WPL: begin
        if (wcnt_q == WCW'(PL_LAST)) begin
          wcnt_d = '0;
          if (WR_HOLD > 0) state_d = S_WHD;
          else             wr_beat_done = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      S_WHD: begin
        if (wcnt_q == WCW'(HD_LAST)) wr_beat_done = 1'b1;
        else                         wcnt_d = wcnt_q + 1'b1;
      end

      S_IO: begin
        if (io_rdy) begin
          if (read_q) rdata_d = io_rdata;
          state_d   = S_IDLE;
          dma_ack_d = dma_q;
        end else if (tcnt_q == TCW'(IO_TO - 1)) begin
          if (read_q) rdata_d = '1;
          io_err_d  = 1'b1;
          state_d   = S_IDLE;
          dma_ack_d = dma_q;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // End of a write beat is shared by WPL (when there is no hold phase) and WHD.
    if (wr_beat_done) begin
      wcnt_d = '0;
      if (last_beat) begin
        state_d   = S_IDLE;
        dma_ack_d = dma_q;
      end else begin
        beat_d = beat_q + 1'b1;
        if (WR_SETUP > 0) state_d = S_WSU;
        else              state_d = S_WPL;
      end
    end

    // Write strobe is registered from the next state so it never glitches.
    we_n_d = (state_d != S_WPL);
  end

  // Outputs
  logic in_wr;
  assign in_wr = (state_q == S_WSU) || (state_q == S_WPL) || (state_q == S_WHD);

  assign rdy      = (state_q == S_IDLE);
  assign rdata    = rdata_q;
  assign dma_ack  = dma_ack_q;
  assign io_err   = io_err_q;
  assign ram_we_n = we_n_q;
  assign xd_oe    = in_wr;
  assign ram_oe_n = !((state_q == S_IDLE) || (state_q == S_RD));
  assign xd_o     = word_q ? wdata_q[beat_q*XW +: XW] : wdata_q[XW-1:0];
  assign io_addr  = addr_q[4:0];
  assign io_rd    = (state_q == S_IO) && read_q;
  assign io_wr    = (state_q == S_IO) && !read_q;
  assign io_wdata = wdata_q;

  generate
    if (LB > 0) begin : g_xa_word
      assign xa = word_q ? {addr_q[AW-1:LB], beat_q} : addr_q;
    end else begin : g_xa_byte
      assign xa = addr_q;
    end
  endgenerate

  always_comb begin
    sel = '0;
    if (state_q == S_IO) sel[addr_q[7 -: SELB]] = 1'b1;
  end

endmodule

// File: tb/tb_xmemctrl.sv
module tb_xmemctrl;
  localparam int W = 16, XW = 8, AW = 16, SELB = 3;
  localparam int RD_WS = 1, WR_SETUP = 1, WR_PULSE = 2, WR_HOLD = 1, IO_TO = 7;
  localparam int NB = W / XW;
  localparam int NSEL = 2 ** SELB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_ce = 1'b0, word_nxt = 1'b0, read_nxt = 1'b0, dma_nxt = 1'b0;
  logic [AW-1:0] addr_nxt = '0;
  logic [W-1:0]  wdata_nxt = '0;
  logic rdy, dma_ack, ram_oe_n, ram_we_n, xd_oe, io_rd, io_wr, io_err, io_rdy;
  logic [W-1:0] rdata, io_wdata;
  logic [W-1:0] io_rdata = '0;
  logic [AW-1:0] xa;
  logic [XW-1:0] xd_o, xd_i;
  logic [NSEL-1:0] sel;
  logic [4:0] io_addr;

  logic [7:0] ram [0:65535];
  int io_k = 0;  // IO cycle in which io_rdy is raised; 0 = never
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  xmemctrl #(
    .W(W), .XW(XW), .AW(AW), .SELB(SELB), .RD_WS(RD_WS), .WR_SETUP(WR_SETUP),
    .WR_PULSE(WR_PULSE), .WR_HOLD(WR_HOLD), .IO_TO(IO_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_ce(mem_ce), .word_nxt(word_nxt), .read_nxt(read_nxt),
    .dma_nxt(dma_nxt), .addr_nxt(addr_nxt), .wdata_nxt(wdata_nxt), .rdy(rdy), .rdata(rdata),
    .dma_ack(dma_ack), .xa(xa), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .xd_o(xd_o),
    .xd_oe(xd_oe), .xd_i(xd_i), .sel(sel), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_rdy(io_rdy), .io_err(io_err)
  );

  assign xd_i = ram[xa];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // kind: 0 = RAM read, 1 = RAM write, 2 = I/O
  logic m_active, m_word, m_read, m_dma, m_ack, m_err;
  int m_t, m_len, m_kind;
  logic [AW-1:0] m_addr;
  logic [W-1:0] m_wdata, m_rdata;

  function automatic logic io_ok();
    return (io_k >= 1) && (io_k <= IO_TO);
  endfunction

  function automatic logic [W-1:0] rd_model(input logic [AW-1:0] a, input logic wd);
    logic [W-1:0] r;
    int base;
    r = '0;
    if (wd) begin
      base = int'(a) - (int'(a) % NB);
      for (int b = 0; b < NB; b++) r[b*XW +: XW] = ram[base + b];
    end else begin
      r[XW-1:0] = ram[a];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_t <= 0; m_len <= 0; m_kind <= 0; m_addr <= '0;
      m_word <= 1'b0; m_read <= 1'b0; m_dma <= 1'b0; m_wdata <= '0;
      m_rdata <= '0; m_ack <= 1'b0; m_err <= 1'b0;
    end else if (!m_active) begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      if (mem_ce) begin
        m_active <= 1'b1; m_t <= 0; m_addr <= addr_nxt; m_word <= word_nxt;
        m_read <= read_nxt; m_dma <= dma_nxt; m_wdata <= wdata_nxt;
        if (addr_nxt[15:8] == 8'hFF) begin
          m_kind <= 2; m_len <= io_ok() ? io_k : IO_TO;
        end else if (read_nxt) begin
          m_kind <= 0; m_len <= (word_nxt ? NB : 1) * (1 + RD_WS);
        end else begin
          m_kind <= 1; m_len <= (word_nxt ? NB : 1) * (WR_SETUP + WR_PULSE + WR_HOLD);
        end
      end
    end else if (m_t == m_len - 1) begin
      m_active <= 1'b0;
      m_ack    <= m_dma;
      m_err    <= (m_kind == 2) && !io_ok();
      if (m_kind == 0) m_rdata <= rd_model(m_addr, m_word);
      else if (m_kind == 2 && m_read) m_rdata <= io_ok() ? io_rdata : '1;
    end else begin
      m_t <= m_t + 1;
    end
  end

  assign io_rdy = m_active && (m_kind == 2) && io_ok() && (m_t == io_k - 1);

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic e_we_n, e_xdoe, e_iord, e_iowr;
    logic [NSEL-1:0] e_sel;
    logic [AW-1:0] e_xa;
    logic [XW-1:0] e_xd;
    int b, ph, p;
    e_we_n = 1'b1; e_xdoe = 1'b0; e_iord = 1'b0; e_iowr = 1'b0; e_sel = '0;
    e_xa = '0; e_xd = '0;
    chk("rdy", rdy, !m_active);
    chk("dma_ack", dma_ack, !m_active && m_ack);
    chk("io_err", io_err, !m_active && m_err);
    if (!m_active) begin
      chk("rdata", rdata, m_rdata);
      chk("idle_oe_n", ram_oe_n, 1'b0);
    end else if (m_kind == 0) begin
      b = m_t / (1 + RD_WS);
      e_xa = m_word ? AW'(int'(m_addr) - (int'(m_addr) % NB) + b) : m_addr;
      chk("rd_xa", xa, e_xa);
      chk("rd_oe_n", ram_oe_n, 1'b0);
    end else if (m_kind == 1) begin
      p  = WR_SETUP + WR_PULSE + WR_HOLD;
      b  = m_t / p;
      ph = m_t % p;
      e_we_n = !(ph >= WR_SETUP && ph < WR_SETUP + WR_PULSE);
      e_xdoe = 1'b1;
      e_xa = m_word ? AW'(int'(m_addr) - (int'(m_addr) % NB) + b) : m_addr;
      e_xd = m_word ? m_wdata[b*XW +: XW] : m_wdata[XW-1:0];
      chk("wr_xa", xa, e_xa);
      chk("wr_xd_o", xd_o, e_xd);
      chk("wr_oe_n", ram_oe_n, 1'b1);
    end else begin
      e_sel = NSEL'(1) << m_addr[7:5];
      e_iord = m_read;
      e_iowr = !m_read;
      chk("io_addr", io_addr, m_addr[4:0]);
      chk("io_wdata", io_wdata, m_wdata);
    end
    chk("ram_we_n", ram_we_n, e_we_n);
    chk("xd_oe", xd_oe, e_xdoe);
    chk("sel", sel, e_sel);
    chk("io_rd", io_rd, e_iord);
    chk("io_wr", io_wr, e_iowr);
  end

  // ---------------- observation for literal checks ----------------
  int lowcnt = 0, ack_cnt = 0, err_cnt = 0, iord_cnt = 0, iowr_cnt = 0;
  int runs[$];
  logic [AW-1:0] xa_tr[$];
  logic we_tr[$];
  logic [NSEL-1:0] sel_seen = '0;

  always @(negedge clk) begin
    if (!rdy) begin
      lowcnt++;
      xa_tr.push_back(xa);
      we_tr.push_back(ram_we_n);
    end else if (lowcnt != 0) begin
      runs.push_back(lowcnt);
      lowcnt = 0;
    end
    if (dma_ack) ack_cnt++;
    if (io_err) err_cnt++;
    if (io_rd) iord_cnt++;
    if (io_wr) iowr_cnt++;
    if (io_rd || io_wr) sel_seen = sel;
  end

  task automatic clr();
    runs.delete(); xa_tr.delete(); we_tr.delete();
    ack_cnt = 0; err_cnt = 0; iord_cnt = 0; iowr_cnt = 0; sel_seen = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic wd, input logic rd, input logic dm,
                       input logic [AW-1:0] a, input logic [W-1:0] d);
    word_nxt = wd; read_nxt = rd; dma_nxt = dm; addr_nxt = a; wdata_nxt = d;
    mem_ce = 1'b1;
    cyc();
    mem_ce = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (!rdy && n < maxc) begin
      cyc();
      n++;
    end
    chk("idle_reached", rdy, 1'b1);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack_we();
    logic [31:0] v;
    v = '0;
    foreach (we_tr[i]) v = {v[30:0], we_tr[i]};
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
    ram[16'h1234] = 8'hCD;
    ram[16'h1235] = 8'hAB;

    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // reset values
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_xa", xa, 16'h0000);
    chk("rst_xd_o", xd_o, 8'h00);
    chk("rst_we_n", ram_we_n, 1'b1);
    chk("rst_oe_n", ram_oe_n, 1'b0);

    // word read, misaligned address
    clr();
    start(1'b1, 1'b1, 1'b0, 16'h1235, 16'h0000);
    wait_idle(20); settle();
    chk("wrd_low", runs.size() > 0 ? runs[0] : 0, 4);
    chk("wrd_xa0", xa_tr[0], 16'h1234);
    chk("wrd_xa1", xa_tr[1], 16'h1234);
    chk("wrd_xa2", xa_tr[2], 16'h1235);
    chk("wrd_xa3", xa_tr[3], 16'h1235);
    chk("wrd_rdata", rdata, 16'hABCD);

    // byte read zero-extends
    clr();
    start(1'b0, 1'b1, 1'b0, 16'h1235, 16'h0000);
    wait_idle(20); settle();
    chk("brd_low", runs.size() > 0 ? runs[0] : 0, 2);
    chk("brd_rdata", rdata, 16'h00AB);

    // byte write
    clr();
    start(1'b0, 1'b0, 1'b0, 16'h0101, 16'h5A77);
    chk("bw_xd_o", xd_o, 8'h77);
    wait_idle(20); settle();
    chk("bw_low", runs.size() > 0 ? runs[0] : 0, 4);
    chk("bw_we_pattern", pack_we(), 32'b1001);
    chk("bw_rdata_kept", rdata, 16'h00AB);

    // I/O read, ready in 3rd cycle
    clr();
    io_k = 3; io_rdata = 16'h1234;
    start(1'b0, 1'b1, 1'b0, 16'hFF45, 16'h0000);
    chk("ior_io_addr", io_addr, 5'd5);
    wait_idle(20); settle();
    chk("ior_low", runs.size() > 0 ? runs[0] : 0, 3);
    chk("ior_sel", sel_seen, 8'h04);
    chk("ior_rd_cnt", iord_cnt, 3);
    chk("ior_rdata", rdata, 16'h1234);
    chk("ior_err_cnt", err_cnt, 0);

    // I/O write, ready never comes
    clr();
    io_k = 0;
    start(1'b0, 1'b0, 1'b0, 16'hFFE0, 16'h9876);
    wait_idle(20); settle();
    chk("iow_low", runs.size() > 0 ? runs[0] : 0, 7);
    chk("iow_sel", sel_seen, 8'h80);
    chk("iow_wr_cnt", iowr_cnt, 7);
    chk("iow_err_cnt", err_cnt, 1);

    // I/O read timeout returns all ones
    clr();
    io_k = 0; io_rdata = 16'h5555;
    start(1'b0, 1'b1, 1'b0, 16'hFF20, 16'h0000);
    wait_idle(20); settle();
    chk("iot_rdata", rdata, 16'hFFFF);
    chk("iot_err_cnt", err_cnt, 1);

    // I/O ready in the first and in the last allowed cycle
    clr();
    io_k = 1; io_rdata = 16'hA5C3;
    start(1'b0, 1'b1, 1'b0, 16'hFF3F, 16'h0000);
    wait_idle(20); settle();
    chk("io1_low", runs.size() > 0 ? runs[0] : 0, 1);
    chk("io1_sel", sel_seen, 8'h02);
    chk("io1_rdata", rdata, 16'hA5C3);
    clr();
    io_k = IO_TO;
    start(1'b0, 1'b0, 1'b0, 16'hFF00, 16'h0F0F);
    wait_idle(20); settle();
    chk("io7_low", runs.size() > 0 ? runs[0] : 0, 7);
    chk("io7_err_cnt", err_cnt, 0);
    io_k = 0;

    // DMA word write, stray mem_ce while busy, then back-to-back DMA word read
    clr();
    start(1'b1, 1'b0, 1'b1, 16'h2000, 16'hBEEF);
    cyc();
    word_nxt = 1'b1; read_nxt = 1'b1; addr_nxt = 16'h4444; mem_ce = 1'b1;
    cyc();
    mem_ce = 1'b0;
    wait_idle(20);
    start(1'b1, 1'b1, 1'b1, 16'h2002, 16'h0000);
    wait_idle(20); settle();
    chk("b2b_runs", runs.size(), 2);
    chk("b2b_wr_low", runs.size() > 0 ? runs[0] : 0, 8);
    chk("b2b_rd_low", runs.size() > 1 ? runs[1] : 0, 4);
    chk("b2b_ack_cnt", ack_cnt, 2);
    chk("b2b_rdata", rdata, 16'h1F1E);

    // reset during the write pulse of a word write
    clr();
    start(1'b1, 1'b0, 1'b1, 16'h3000, 16'hC3A5);
    cyc();
    chk("rstm_we_low", ram_we_n, 1'b0);
    chk("rstm_xdoe_high", xd_oe, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_we_async", ram_we_n, 1'b1);
    chk("rstm_xdoe_async", xd_oe, 1'b0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("rstm_rdy", rdy, 1'b1);
    chk("rstm_ack_cnt", ack_cnt, 0);
    chk("rstm_rdata", rdata, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
